// File: rtl/dsp_pkg.sv
// dsp_pkg: widths and state encoding shared by the dot-product datapath
// (multiplier array and mac_accum).
//   DATA_WID : multiplier operand width
//   SIZE     : products summed per dot product
//   ACC_WID  : accumulator width, wide enough that SIZE full-scale products never wrap
//   state_e  : mac_accum FSM encoding
package dsp_pkg;

  localparam int DATA_WID = 16;
  localparam int SIZE     = 8;
  localparam int ACC_WID  = 2*DATA_WID + $clog2(SIZE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/mac_accum.sv
// mac_accum: sums SIZE signed products into one dot product and hands it
// downstream over a valid/ready pair.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no partial sum; next accepted product starts a vector
// ACC   | partial sum in acc, cnt products taken so far
// HOLD  | out_data holds a finished dot product until out_ready
//
// Ports
//   clock, rst_n     : clock, async active-low reset
//   flush            : synchronous abort of the current vector
//   in_valid/in_ready/in_data    : product input (2*DATA_WID signed)
//   out_valid/out_ready/out_data : dot product output (ACC_WID signed)
//   busy             : partial sum in progress (state ACC)
module mac_accum
  import dsp_pkg::*;
#(
  parameter  int DATA_WID = dsp_pkg::DATA_WID,
  parameter  int SIZE     = dsp_pkg::SIZE,
  localparam int ACC_WID  = 2*DATA_WID + $clog2(SIZE)
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*DATA_WID-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WID-1:0]    out_data,
  output logic                  busy
);

  localparam int CNT_WID = $clog2(SIZE) + 1;
  localparam logic [CNT_WID-1:0] CNT_LAST = CNT_WID'(SIZE - 1);

  state_e                     state;
  logic signed [ACC_WID-1:0]  acc;
  logic        [CNT_WID-1:0]  cnt;
  logic signed [ACC_WID-1:0]  prod_ext;
  logic                       xfer;

  assign prod_ext = ACC_WID'($signed(in_data));

  // In HOLD a new product may only enter while the result leaves, so the
  // pending output is never overwritten.
  always_comb begin
    in_ready = 1'b1;
    if (flush)
      in_ready = 1'b0;
    else if (state == ST_HOLD)
      in_ready = out_ready;
  end

  assign xfer = in_valid && in_ready;
  assign busy = (state == ST_ACC);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            if (SIZE == 1) begin
              out_data  <= prod_ext;
              out_valid <= 1'b1;
              cnt       <= '0;
              state     <= ST_HOLD;
            end else begin
              acc   <= prod_ext;
              cnt   <= CNT_WID'(1);
              state <= ST_ACC;
            end
          end
        end

        ST_ACC: begin
          if (xfer) begin
            if (cnt == CNT_LAST) begin
              out_data  <= acc + prod_ext;
              out_valid <= 1'b1;
              cnt       <= '0;
              state     <= ST_HOLD;
            end else begin
              acc <= acc + prod_ext;
              cnt <= cnt + 1'b1;
            end
          end
        end

        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
            // xfer implies out_ready here: start the next vector with no bubble.
            if (xfer) begin
              if (SIZE == 1) begin
                out_data  <= prod_ext;
                out_valid <= 1'b1;
                cnt       <= '0;
                state     <= ST_HOLD;
              end else begin
                acc   <= prod_ext;
                cnt   <= CNT_WID'(1);
                state <= ST_ACC;
              end
            end
          end
        end

        default: begin
          state     <= ST_IDLE;
          acc       <= '0;
          cnt       <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accum.sv
// tb_mac_accum: directed vectors with hand-computed dot products for mac_accum
// (DATA_WID=16, SIZE=8). Inputs change on the falling edge; outputs are
// sampled on the falling edge or shortly after an input change.
module tb_mac_accum;

  localparam int ACC_WID = 35;

  logic               clock;
  logic               rst_n;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_data;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_WID-1:0] out_data;
  logic               busy;

  int n_checks;
  int n_errors;

  mac_accum dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offer n copies of d back-to-back; returns at a falling edge with in_valid low.
  task automatic run_vec(input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clock);
      @(negedge clock);
    end
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    check("consume_out_valid", out_valid, 0);
    check("consume_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    @(negedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    @(negedge clock);

    // Eight (-1)*(-7) products back-to-back.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h0000_0007;
      @(posedge clock);
      @(negedge clock);
      if (i == 0) check("v1_busy_first", busy, 1);
      if (i == 6) check("v1_no_early_valid", out_valid, 0);
    end
    in_valid = 1'b0;
    check("v1_out_valid", out_valid, 1);
    check("v1_out_data", $signed(out_data), 56);
    check("v1_busy_hold", busy, 0);
    consume();

    // Alternating 7 / 18 with one idle cycle between products.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = (i % 2 == 0) ? 32'h0000_0007 : 32'h0000_0012;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      if (i < 7) begin
        @(posedge clock);
        @(negedge clock);
        if (i == 3) check("v2_busy_gap", busy, 1);
        if (i == 6) check("v2_busy_gap_late", busy, 1);
      end
    end
    check("v2_out_valid", out_valid, 1);
    check("v2_out_data", $signed(out_data), 100);
    consume();

    // Large positive and large negative products: must not wrap.
    run_vec(8, 32'h4000_0000);
    check("v3_pos_data", $signed(out_data), 64'sh2_0000_0000);
    consume();
    run_vec(8, 32'hC000_8000);
    check("v3_neg_data", $signed(out_data), -64'sd8589672448);
    consume();

    // Backpressure: result held for 5 cycles while a product waits.
    run_vec(8, 32'h0000_0001);
    in_valid = 1'b1;
    in_data  = 32'h0000_0005;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("v4_hold_in_ready", in_ready, 0);
      check("v4_hold_valid", out_valid, 1);
      check("v4_hold_data", $signed(out_data), 8);
      @(posedge clock);
      @(negedge clock);
    end
    out_ready = 1'b1;
    #1;
    check("v4_release_in_ready", in_ready, 1);
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    check("v4_release_valid", out_valid, 0);
    check("v4_release_busy", busy, 1);
    run_vec(7, 32'h0000_0005);
    check("v4_next_valid", out_valid, 1);
    check("v4_next_data", $signed(out_data), 40);
    consume();

    // Flush mid-vector, then a fresh vector of ones.
    run_vec(3, 32'h0000_0007);
    check("v5_busy_pre_flush", busy, 1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h0000_0007;
    #1;
    check("v5_flush_in_ready", in_ready, 0);
    @(posedge clock);
    @(negedge clock);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("v5_flush_busy", busy, 0);
    check("v5_flush_valid", out_valid, 0);
    run_vec(8, 32'h0000_0001);
    check("v5_after_flush_data", $signed(out_data), 8);
    check("v5_after_flush_valid", out_valid, 1);

    // Reset while holding a result: output drops without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("v6_rst_valid", out_valid, 0);
    check("v6_rst_data", out_data, 0);
    check("v6_rst_busy", busy, 0);
    @(negedge clock);
    rst_n = 1'b1;
    #1;
    check("v6_rst_in_ready", in_ready, 1);
    run_vec(8, 32'h0000_0002);
    check("v6_new_vec_data", $signed(out_data), 16);
    consume();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
